// File: rtl/agat9_kbd_host_rx.sv
// agat9_kbd_host_rx
//   Host-side receiver for the Agat-9 keyboard connector. Generates the
//   keyboard scan clock, deserializes framed LSB-first key codes sampled on
//   the falling edge of that clock, and holds the last code behind a sticky
//   strobe for the CPU. The keyboard reset and Rus/Lat lines are
//   synchronized; the reset line is additionally filtered into a single
//   request pulse.
//
// Ports
//   clock, reset   system clock, synchronous active-high reset
//   kbd_clock      scan clock to keyboard (idles high)
//   kbd_data       serial data from keyboard (asynchronous)
//   kbd_reset_n    keyboard reset request, active-low (asynchronous)
//   kbd_rus_lat    keyboard Rus/Lat level (asynchronous)
//   kbd_reply      1 = host ready for a new code (advisory)
//   key_code       last delivered code
//   key_strobe     sticky new-code flag
//   key_ack        one-cycle CPU read pulse; clears strobe/overrun/frame_err
//   overrun        sticky: a code was dropped while strobe was set
//   frame_err      sticky: stop bit sampled low
//   rus_lat        synchronized kbd_rus_lat
//   reset_req      one-cycle pulse per filtered keyboard reset
module agat9_kbd_host_rx #(
  parameter int CLK_DIV     = 16,
  parameter int DATA_BITS   = 7,
  parameter int SYNC_STAGES = 2,
  parameter int RST_FILT    = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 kbd_clock,
  input  logic                 kbd_data,
  input  logic                 kbd_reset_n,
  input  logic                 kbd_rus_lat,
  output logic                 kbd_reply,
  output logic [DATA_BITS-1:0] key_code,
  output logic                 key_strobe,
  input  logic                 key_ack,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 rus_lat,
  output logic                 reset_req
);

  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam int FILT_W = $clog2(RST_FILT + 1);

  localparam logic [DIV_W-1:0]       DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]       BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [FILT_W-1:0]      FILT_LAST = FILT_W'(RST_FILT - 1);
  localparam logic [SYNC_STAGES-1:0] SYNC_ONES = '1;
  // The Rus/Lat chain's last stage is the rus_lat output itself, which
  // must come out of reset low while the earlier stages idle high.
  localparam logic [SYNC_STAGES-1:0] RL_INIT   = SYNC_ONES >> 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP, S_WAIT} state_t;

  logic [DIV_W-1:0]       div_cnt;
  logic                   div_wrap;
  logic                   tick;
  logic [SYNC_STAGES-1:0] data_sync;
  logic [SYNC_STAGES-1:0] rstn_sync;
  logic [SYNC_STAGES-1:0] rl_sync;
  logic                   sd;
  logic                   rn;
  state_t                 state, state_nx;
  logic [BIT_W-1:0]       bitcnt, bitcnt_nx;
  logic [DATA_BITS-1:0]   shreg, shreg_nx;
  logic                   deliver_nx, ferr_nx;
  logic                   deliver_p1;
  logic                   ack_eff;
  logic [FILT_W-1:0]      filt_cnt;
  logic                   armed;

  // ---- scan clock divider; sample tick = the 1->0 toggle of kbd_clock
  assign div_wrap = (div_cnt == DIV_LAST);
  assign tick     = div_wrap & kbd_clock;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt   <= '0;
      kbd_clock <= 1'b1;
    end else if (div_wrap) begin
      div_cnt   <= '0;
      kbd_clock <= ~kbd_clock;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
    end
  end

  // ---- input synchronizers
  always_ff @(posedge clock) begin
    if (reset) begin
      data_sync <= SYNC_ONES;
      rstn_sync <= SYNC_ONES;
      rl_sync   <= RL_INIT;
    end else begin
      data_sync <= (data_sync << 1) | SYNC_STAGES'(kbd_data);
      rstn_sync <= (rstn_sync << 1) | SYNC_STAGES'(kbd_reset_n);
      rl_sync   <= (rl_sync << 1)   | SYNC_STAGES'(kbd_rus_lat);
    end
  end

  assign sd      = data_sync[SYNC_STAGES-1];
  assign rn      = rstn_sync[SYNC_STAGES-1];
  assign rus_lat = rl_sync[SYNC_STAGES-1];

  // ---- frame FSM, advances only on sample ticks
  always_comb begin
    state_nx   = state;
    bitcnt_nx  = bitcnt;
    shreg_nx   = shreg;
    deliver_nx = 1'b0;
    ferr_nx    = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE: begin
          if (!sd) begin
            state_nx  = S_DATA;
            bitcnt_nx = '0;
          end
        end
        S_DATA: begin
          shreg_nx  = {sd, shreg[DATA_BITS-1:1]};
          bitcnt_nx = bitcnt + 1'b1;
          if (bitcnt == BIT_LAST) state_nx = S_STOP;
        end
        S_STOP: begin
          if (sd) begin
            deliver_nx = 1'b1;
            state_nx   = S_IDLE;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = S_WAIT;
          end
        end
        S_WAIT: begin
          // Hold off until the line returns idle-high so a broken frame
          // cannot be mistaken for a new start bit.
          if (sd) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      deliver_p1 <= 1'b0;
    end else begin
      state      <= state_nx;
      bitcnt     <= bitcnt_nx;
      shreg      <= shreg_nx;
      deliver_p1 <= deliver_nx;
    end
  end

  // ---- CPU-facing holding register (delivery one cycle after STOP tick)
  assign ack_eff = key_ack & key_strobe;

  always_ff @(posedge clock) begin
    if (reset) begin
      key_code   <= '0;
      key_strobe <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      kbd_reply  <= 1'b1;
    end else begin
      kbd_reply <= ~key_strobe;
      // A read in the delivery cycle frees the slot, so the new code lands.
      if (deliver_p1 && (!key_strobe || key_ack)) begin
        key_code   <= shreg;
        key_strobe <= 1'b1;
      end else if (ack_eff) begin
        key_strobe <= 1'b0;
      end
      if (deliver_p1 && key_strobe && !key_ack) overrun <= 1'b1;
      else if (ack_eff)                         overrun <= 1'b0;
      if (ferr_nx)      frame_err <= 1'b1;
      else if (ack_eff) frame_err <= 1'b0;
    end
  end

  // ---- keyboard reset filter: one pulse per long-enough low period
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_cnt  <= '0;
      armed     <= 1'b1;
      reset_req <= 1'b0;
    end else begin
      reset_req <= 1'b0;
      if (rn) begin
        filt_cnt <= '0;
        armed    <= 1'b1;
      end else if (armed) begin
        if (filt_cnt == FILT_LAST) begin
          reset_req <= 1'b1;
          armed     <= 1'b0;
          filt_cnt  <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_agat9_kbd_host_rx.sv
// Directed testbench for agat9_kbd_host_rx: a simple keyboard model drives
// framed codes on the rising edge of kbd_clock; outputs are checked with
// immediate assertions against hand-computed values.
module tb_agat9_kbd_host_rx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       kbd_clock;
  logic       kbd_data = 1'b1;
  logic       kbd_reset_n = 1'b1;
  logic       kbd_rus_lat = 1'b0;
  logic       kbd_reply;
  logic [6:0] key_code;
  logic       key_strobe;
  logic       key_ack = 1'b0;
  logic       overrun;
  logic       frame_err;
  logic       rus_lat;
  logic       reset_req;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int rr_count = 0;

  agat9_kbd_host_rx dut (
    .clock       (clock),
    .reset       (reset),
    .kbd_clock   (kbd_clock),
    .kbd_data    (kbd_data),
    .kbd_reset_n (kbd_reset_n),
    .kbd_rus_lat (kbd_rus_lat),
    .kbd_reply   (kbd_reply),
    .key_code    (key_code),
    .key_strobe  (key_strobe),
    .key_ack     (key_ack),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .rus_lat     (rus_lat),
    .reset_req   (reset_req)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (reset_req === 1'b1) rr_count <= rr_count + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_kclk_rise();
    logic prev;
    prev = kbd_clock;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      if (!prev && kbd_clock) return;
      prev = kbd_clock;
    end
  endtask

  task automatic wait_kclk_fall();
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      if (!kbd_clock) return;
    end
  endtask

  // which: 0 = key_strobe, 1 = overrun, 2 = frame_err
  task automatic wait_sig(input int which);
    for (int i = 0; i < 300; i++) begin
      @(posedge clock);
      #1;
      if (which == 0 && key_strobe) return;
      if (which == 1 && overrun)    return;
      if (which == 2 && frame_err)  return;
    end
  endtask

  function automatic logic [8:0] frm(input logic [6:0] c, input logic stop);
    return {stop, c, 1'b0};
  endfunction

  // Drives the first nbits bits of a frame, each on a kbd_clock rising edge.
  task automatic send(input logic [8:0] frame, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      wait_kclk_rise();
      kbd_data = frame[b];
    end
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    cyc(1);
    key_ack = 1'b0;
  endtask

  initial begin
    // reset values
    cyc(3);
    check("rst_kbd_clock", kbd_clock, 1);
    check("rst_kbd_reply", kbd_reply, 1);
    check("rst_key_code", key_code, 0);
    check("rst_strobe", key_strobe, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rus_lat", rus_lat, 0);
    check("rst_reset_req", reset_req, 0);
    reset = 1'b0;
    cyc(1);

    // 1: frame 0x41
    send(frm(7'h41, 1'b1), 9);
    wait_sig(0);
    check("t1_code", key_code, 7'h41);
    check("t1_strobe", key_strobe, 1);
    check("t1_reply_same", kbd_reply, 1);
    cyc(1);
    check("t1_reply_next", kbd_reply, 0);

    // 2: overrun with 0x12
    send(frm(7'h12, 1'b1), 9);
    wait_sig(1);
    check("t2_overrun", overrun, 1);
    check("t2_code_kept", key_code, 7'h41);
    check("t2_strobe", key_strobe, 1);
    ack_pulse();
    check("t2_ack_strobe", key_strobe, 0);
    check("t2_ack_overrun", overrun, 0);
    check("t2_ack_code", key_code, 7'h41);
    cyc(1);
    check("t2_reply", kbd_reply, 1);

    // 3: ack in the delivery cycle of 0x33
    send(frm(7'h22, 1'b1), 9);
    wait_sig(0);
    check("t3_code22", key_code, 7'h22);
    send(frm(7'h33, 1'b1), 9);
    wait_kclk_fall();
    ack_pulse();
    check("t3_code33", key_code, 7'h33);
    check("t3_strobe", key_strobe, 1);
    check("t3_overrun", overrun, 0);
    ack_pulse();
    check("t3_clear", key_strobe, 0);

    // 4: stop bit low, then valid 0x05
    send(frm(7'h2A, 1'b0), 9);
    wait_kclk_rise();
    kbd_data = 1'b1;
    check("t4_frame_err", frame_err, 1);
    check("t4_no_strobe", key_strobe, 0);
    check("t4_code_kept", key_code, 7'h33);
    send(frm(7'h05, 1'b1), 9);
    wait_sig(0);
    check("t4_code05", key_code, 7'h05);
    check("t4_err_sticky", frame_err, 1);
    ack_pulse();
    check("t4_ack_err", frame_err, 0);
    check("t4_ack_strobe", key_strobe, 0);

    // Rus/Lat latency
    kbd_rus_lat = 1'b1;
    cyc(1);
    check("rl_lat1", rus_lat, 0);
    cyc(1);
    check("rl_lat2", rus_lat, 1);

    // 5: reset request filter
    kbd_reset_n = 1'b0;
    cyc(63);
    kbd_reset_n = 1'b1;
    cyc(10);
    check("t5_63_low", rr_count, 0);
    kbd_reset_n = 1'b0;
    cyc(100);
    kbd_reset_n = 1'b1;
    cyc(10);
    check("t5_100_low", rr_count, 1);
    kbd_reset_n = 1'b0;
    cyc(40);
    kbd_reset_n = 1'b1;
    cyc(1);
    kbd_reset_n = 1'b0;
    cyc(40);
    kbd_reset_n = 1'b1;
    cyc(10);
    check("t5_glitch", rr_count, 1);
    kbd_reset_n = 1'b0;
    cyc(64);
    kbd_reset_n = 1'b1;
    cyc(10);
    check("t5_64_low", rr_count, 2);
    check("t5_no_self_reset", key_code, 7'h05);

    // 6: reset after bit 3 of a frame, then 0x7F
    send(frm(7'h00, 1'b1), 5);
    cyc(5);
    kbd_data = 1'b1;
    reset = 1'b1;
    cyc(2);
    check("t6_kbd_clock", kbd_clock, 1);
    check("t6_reply", kbd_reply, 1);
    check("t6_code", key_code, 0);
    check("t6_strobe", key_strobe, 0);
    check("t6_overrun", overrun, 0);
    check("t6_frame_err", frame_err, 0);
    check("t6_rus_lat", rus_lat, 0);
    check("t6_reset_req", reset_req, 0);
    reset = 1'b0;
    cyc(1);
    send(frm(7'h7F, 1'b1), 9);
    wait_sig(0);
    check("t6_code7f", key_code, 7'h7F);
    check("t6_strobe7f", key_strobe, 1);
    check("t6_overrun7f", overrun, 0);
    check("t6_err7f", frame_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
